ampel_key_request: RTL

- Upstream input stage for the Ampel traffic-light controller; registered single-clock block.
- Synchronises and debounces the two raw, active-low push buttons (key0, key1).
- Produces one-cycle press pulses and a sticky pedestrian request `req`, held until the light controller acknowledges it with `ack` when the pedestrian phase starts.
- Replaces the controller's unsynchronised dual-edge button capture.

---
 rtl/ampel_key_request_if.sv | 28 ++
 rtl/ampel_key_request.sv | 84 ++++++++
 2 files changed

// File: rtl/ampel_key_request_if.sv
`default_nettype none
// ============================================================================
// Module   : ampel_key_request_if
// Brief    : Button/request bundle between the Ampel key stage and its user.
// Revision : 1.0
// ============================================================================
interface ampel_key_request_if #(
  parameter int COUNT_W = 8
);
  logic               key0;
  logic               key1;
  logic               ack;
  logic [1:0]         key_state;
  logic [1:0]         press;
  logic               req;
  logic [COUNT_W-1:0] req_count;

  modport master (
    output key0, key1, ack,
    input  key_state, press, req, req_count
  );

  modport slave (
    input  key0, key1, ack,
    output key_state, press, req, req_count
  );
endinterface
`default_nettype wire

// File: rtl/ampel_key_request.sv
`default_nettype none
// ============================================================================
// Module   : ampel_key_request
// Brief    : Synchronise/debounce two active-low keys, emit press pulses and a
//            sticky pedestrian request cleared by ack.
// Revision : 1.0
// ============================================================================
module ampel_key_request #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int COUNT_W         = 8
) (
  input  wire logic           CLOCK_50,
  input  wire logic           reset,
  ampel_key_request_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         r_s1;
  logic [1:0]         r_s2;
  logic [CNT_W-1:0]   r_cnt [2];
  logic [1:0]         r_key_state;
  logic [1:0]         r_press;
  logic               r_req;
  logic [COUNT_W-1:0] r_req_count;

  logic [1:0]         w_raw_pressed;
  logic [1:0]         w_diff;
  logic [1:0]         w_done;
  logic [1:0]         w_rise;
  logic               w_set;

  always_comb begin
    w_raw_pressed = ~r_s2;
    w_diff        = w_raw_pressed ^ r_key_state;
    w_done        = 2'b00;
    for (int n = 0; n < 2; n++) begin
      w_done[n] = w_diff[n] && (r_cnt[n] == c_CNT_MAX);
    end
    // Only a debounced 0->1 transition produces a press pulse.
    w_rise = w_done & ~r_key_state;
    w_set  = |r_press;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_s1        <= 2'b11;
      r_s2        <= 2'b11;
      r_cnt[0]    <= '0;
      r_cnt[1]    <= '0;
      r_key_state <= 2'b00;
      r_press     <= 2'b00;
      r_req       <= 1'b0;
      r_req_count <= '0;
    end else begin
      r_s1 <= {bus.key1, bus.key0};
      r_s2 <= r_s1;
      for (int n = 0; n < 2; n++) begin
        if (!w_diff[n]) begin
          r_cnt[n] <= '0;
        end else if (w_done[n]) begin
          r_cnt[n]       <= '0;
          r_key_state[n] <= ~r_key_state[n];
        end else begin
          r_cnt[n] <= r_cnt[n] + CNT_W'(1);
        end
      end
      r_press <= w_rise;
      // A fresh press beats a simultaneous ack; merged presses are not counted.
      r_req <= w_set | (r_req & ~bus.ack);
      if (w_set && !r_req) begin
        r_req_count <= r_req_count + COUNT_W'(1);
      end
    end
  end

  assign bus.key_state = r_key_state;
  assign bus.press     = r_press;
  assign bus.req       = r_req;
  assign bus.req_count = r_req_count;

endmodule
`default_nettype wire
